mem_ctrl: RTL
=============

# mem_ctrl

Single-port memory controller placed directly downstream of the CPU core's external memory interface. It accepts level-held instruction-fetch, load and store requests, arbitrates them onto one word-wide memory bus with a req/ack handshake and arbitrary wait states, and returns read data with a one-cycle done pulse per requester. It also provides a stall indication to the core, a bus-timeout watchdog, and an optional single-entry instruction buffer.

## Interface
Parameters:
- W, `WORD_WIDTH (32): data and address width.
- MAX_WAIT, 16: the number of BUSY cycles without `mem_ack` after which the access is aborted. Must be at least 1.
- CNT_W, 5: watchdog counter width. Must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-low.
- inst_req  in  1  fetch request; held until `inst_done`.
- pc  in  W  fetch address; stable while `inst_req` is high.
- read_inst  out  W  fetched word; valid while `inst_done` is high and held afterwards.
- inst_done  out  1  one-cycle completion pulse for a fetch.
- load_req  in  1  load request; held until `load_done`.
- l_addr  in  W  load address.
- l_data  out  W  loaded word; valid while `load_done` is high and held afterwards.
- load_done  out  1  one-cycle completion pulse for a load.
- store_req  in  1  store request; held until `store_done`.
- s_addr  in  W  store address.
- s_data  in  W  store data.
- store_done  out  1  one-cycle completion pulse for a store.
- stall  out  1  combinational: (inst_req & ~inst_done) | (load_req & ~load_done) | (store_req & ~store_done).
- err  out  1  high together with a done pulse when that access timed out.
- mem_req  out  1  bus request; held until the `mem_ack` cycle.
- mem_we  out  1  bus write enable.
- mem_addr  out  W  word address; bits [1:0] are forced to 0.
- mem_wdata  out  W  bus write data.
- mem_ack  in  1  bus acknowledge; `mem_rdata` is valid in the same cycle.
- mem_rdata  in  W  bus read data.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Arbitration uses fixed priority: store, then load, then fetch.
  - When the winning request is granted, the FSM latches its type, address and data into `mem_addr`, `mem_wdata` and `mem_we`, raises `mem_req`, and moves to BUSY.
  - With no request pending, the FSM stays in IDLE.
- BUSY:
  - `mem_req` stays high and the watchdog increments every cycle.
  - On `mem_ack`:
    - For a read, `mem_rdata` is registered into `read_inst` or `l_data` according to the latched type.
    - `mem_req` and `mem_we` drop, and the FSM moves to DONE.
  - Timeout: if the watchdog reaches MAX_WAIT with no ack, `mem_req` drops, the destination register is loaded with 0, `err` is set, and the FSM moves to DONE. If `mem_ack` and timeout occur in the same cycle, the ack wins and `err` stays 0.
- DONE:
  - The matching `*_done` (and `err`, if set) is high for exactly this cycle, then the FSM returns to IDLE.
  - The watchdog clears. New requests are never sampled in DONE.
- Requesters drop their request in the cycle after their done pulse. This prevents a served request from being re-granted.
- `mem_ack` is ignored outside BUSY.
- `mem_addr` and `mem_wdata` hold their last values while idle.
- Reset (`rst` = 0 at an edge):
  - The FSM goes to IDLE.
  - All outputs reset to 0: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `read_inst`, `l_data`, `*_done`, `err`.
  - An in-flight access is abandoned with no done pulse.
  - `stall` still follows its combinational formula.

## Timing
- A request first seen in IDLE in cycle 0 drives `mem_req` from cycle 1.
- With `mem_ack` in cycle A ≥ 1, the done pulse is in cycle A+1. Zero-wait-state memory (ack in cycle 1) gives done in cycle 2.
- A timeout gives done in cycle MAX_WAIT+1.
- The earliest next grant is at the IDLE cycle after DONE. The bus therefore has at least one idle cycle between accesses.
- A lower-priority request waits until higher-priority requests have been served. There is no starvation guarantee for fetch.

## Configuration
`MEM_CTRL_IBUF_EN` enables the single-entry instruction buffer. The buffer holds a valid bit, a tag (address[W-1:2]) and a data word.

- **Filling:** every fetch that completes without `err` writes tag and data and sets the valid bit.
- **Hit:** in IDLE, if fetch is the winning request and `pc` hits the buffer, no bus access occurs. The FSM goes directly to DONE with `read_inst` set to the buffered word, so `inst_done` is in cycle 1.
- **Store coherence:** a store whose completed address matches the tag updates the buffered data (write-through). A store that times out clears the valid bit.
- **Reset:** clears the valid bit.

Without the macro, every fetch uses the bus and no buffer state exists.

## Test plan
- Reset: hold `rst` = 0 for 2 cycles with `mem_req` active → all outputs are 0 and the FSM is in IDLE; a late `mem_ack` produces no done pulse.
- Single fetch: `pc` = 0x0040_0004 with `mem_ack` in cycle 3 and `mem_rdata` = 0x2408_0005 → `mem_addr` = 0x0040_0004 in cycles 1–3, then `inst_done` with `read_inst` = 0x2408_0005 in cycle 4.
- Priority: `inst_req` and `load_req` (`l_addr` = 0x1000_0002) both asserted in cycle 0 → the load is served first with `mem_addr` = 0x1000_0000, and the fetch is granted in the IDLE cycle after `load_done`.
- Store: `s_addr` = 0x1000_0008, `s_data` = 0xDEAD_BEEF → `mem_we` = 1 with matching `mem_wdata`, then `store_done` with `err` = 0.
- Timeout: MAX_WAIT = 4 and `mem_ack` never asserted → `mem_req` is high in cycles 1–4, then `load_done`, `err` and `l_data` = 0 in cycle 5. A separate case with ack exactly in cycle 4 must give `err` = 0.
- IBUF (macro on): fetch 0x100 (fill), store 0x1234_5678 to 0x100, fetch 0x100 again → no `mem_req`, `inst_done` in cycle 1 with `read_inst` = 0x1234_5678.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: core request/response and memory bus signals of mem_ctrl.
// slave = controller side, master = core plus memory side.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

interface mem_ctrl_if #(
  parameter int W = `WORD_WIDTH
);
  logic         inst_req;
  logic [W-1:0] pc;
  logic [W-1:0] read_inst;
  logic         inst_done;
  logic         load_req;
  logic [W-1:0] l_addr;
  logic [W-1:0] l_data;
  logic         load_done;
  logic         store_req;
  logic [W-1:0] s_addr;
  logic [W-1:0] s_data;
  logic         store_done;
  logic         stall;
  logic         err;
  logic         mem_req;
  logic         mem_we;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic         mem_ack;
  logic [W-1:0] mem_rdata;

  modport slave (
    input  inst_req, pc, load_req, l_addr,
    input  store_req, s_addr, s_data,
    input  mem_ack, mem_rdata,
    output read_inst, inst_done, l_data, load_done,
    output store_done, stall, err,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output inst_req, pc, load_req, l_addr,
    output store_req, s_addr, s_data,
    output mem_ack, mem_rdata,
    input  read_inst, inst_done, l_data, load_done,
    input  store_done, stall, err,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates fetch/load/store onto one req/ack memory bus.
// MEM_CTRL_IBUF_EN adds a single-entry instruction buffer.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module mem_ctrl #(
  parameter int W        = `WORD_WIDTH,
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 5
) (
  input logic      clk,
  input logic      rst,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {T_INST, T_LOAD, T_STORE} kind_t;

  localparam logic [W-1:0] AMASK = {{(W-2){1'b1}}, 2'b00};
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_WAIT - 1);

  state_t         state_q;
  kind_t          kind_q;
  logic [CNT_W-1:0] wd_q;
  logic           mem_req_q;
  logic           mem_we_q;
  logic [W-1:0]   mem_addr_q;
  logic [W-1:0]   mem_wdata_q;
  logic [W-1:0]   read_inst_q;
  logic [W-1:0]   l_data_q;
  logic           inst_done_q;
  logic           load_done_q;
  logic           store_done_q;
  logic           err_q;

  logic           gnt_st;
  logic           gnt_ld;
  logic           gnt_if;
  logic [W-1:0]   sel_addr;
  logic           ibuf_hit;

`ifdef MEM_CTRL_IBUF_EN
  logic           ibuf_vld_q;
  logic [W-3:0]   ibuf_tag_q;
  logic [W-1:0]   ibuf_data_q;
`endif

  // fixed-priority grant (store > load > fetch), one-hot
  always_comb begin
    gnt_st   = bus.store_req;
    gnt_ld   = bus.load_req & ~bus.store_req;
    gnt_if   = bus.inst_req & ~bus.load_req & ~bus.store_req;
    sel_addr = bus.pc;
    if (gnt_st)
      sel_addr = bus.s_addr;
    else if (gnt_ld)
      sel_addr = bus.l_addr;
    ibuf_hit = 1'b0;
`ifdef MEM_CTRL_IBUF_EN
    ibuf_hit = ibuf_vld_q && (ibuf_tag_q == bus.pc[W-1:2]);
`endif
  end

  // controller FSM with registered bus and response outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      kind_q       <= T_INST;
      wd_q         <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      read_inst_q  <= '0;
      l_data_q     <= '0;
      inst_done_q  <= 1'b0;
      load_done_q  <= 1'b0;
      store_done_q <= 1'b0;
      err_q        <= 1'b0;
`ifdef MEM_CTRL_IBUF_EN
      ibuf_vld_q   <= 1'b0;
      ibuf_tag_q   <= '0;
      ibuf_data_q  <= '0;
`endif
    end else begin
      inst_done_q  <= 1'b0;
      load_done_q  <= 1'b0;
      store_done_q <= 1'b0;
      err_q        <= 1'b0;
      unique case (state_q)
        IDLE: begin
          wd_q <= '0;
          unique case (1'b1)
            gnt_st: begin
              kind_q      <= T_STORE;
              mem_addr_q  <= sel_addr & AMASK;
              mem_wdata_q <= bus.s_data;
              mem_we_q    <= 1'b1;
              mem_req_q   <= 1'b1;
              state_q     <= BUSY;
            end
            gnt_ld: begin
              kind_q     <= T_LOAD;
              mem_addr_q <= sel_addr & AMASK;
              mem_we_q   <= 1'b0;
              mem_req_q  <= 1'b1;
              state_q    <= BUSY;
            end
            gnt_if: begin
              kind_q <= T_INST;
              if (ibuf_hit) begin
`ifdef MEM_CTRL_IBUF_EN
                read_inst_q <= ibuf_data_q;
`endif
                inst_done_q <= 1'b1;
                state_q     <= DONE;
              end else begin
                mem_addr_q <= sel_addr & AMASK;
                mem_we_q   <= 1'b0;
                mem_req_q  <= 1'b1;
                state_q    <= BUSY;
              end
            end
            default: ;
          endcase
        end
        BUSY: begin
          if (bus.mem_ack || wd_q == WD_LAST) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            err_q     <= ~bus.mem_ack;
            state_q   <= DONE;
            unique case (kind_q)
              T_INST: begin
                read_inst_q <= bus.mem_ack ? bus.mem_rdata : '0;
                inst_done_q <= 1'b1;
`ifdef MEM_CTRL_IBUF_EN
                if (bus.mem_ack) begin
                  ibuf_vld_q  <= 1'b1;
                  ibuf_tag_q  <= mem_addr_q[W-1:2];
                  ibuf_data_q <= bus.mem_rdata;
                end
`endif
              end
              T_LOAD: begin
                l_data_q    <= bus.mem_ack ? bus.mem_rdata : '0;
                load_done_q <= 1'b1;
              end
              default: begin
                store_done_q <= 1'b1;
`ifdef MEM_CTRL_IBUF_EN
                if (!bus.mem_ack)
                  ibuf_vld_q <= 1'b0;
                else if (ibuf_tag_q == mem_addr_q[W-1:2])
                  ibuf_data_q <= mem_wdata_q;
`endif
              end
            endcase
          end else begin
            wd_q <= wd_q + CNT_W'(1);
          end
        end
        default: begin
          wd_q    <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.read_inst  = read_inst_q;
  assign bus.l_data     = l_data_q;
  assign bus.inst_done  = inst_done_q;
  assign bus.load_done  = load_done_q;
  assign bus.store_done = store_done_q;
  assign bus.err        = err_q;
  assign bus.stall      = (bus.inst_req & ~inst_done_q)
                        | (bus.load_req & ~load_done_q)
                        | (bus.store_req & ~store_done_q);

endmodule
